press_decoder: RTL and testbench
================================

# press_decoder

Converts one debounced, clock-synchronous button level into single-cycle key events: press, release, long-press and auto-repeat. It sits between the debouncer output of each keypad button and the lock's code-entry logic, so that logic consumes clean one-cycle strobes instead of levels. Counting is in `clk` cycles; timing thresholds are parameters.

## Interface
- `HOLD_CYCLES`, default 50_000_000: cycles the button must stay down after the press strobe before `long_press` fires; legal range ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: period of `repeat` strobes once in HELD; legal range ≥ 2.
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `btn`, input, 1: debounced button level, already synchronous to `clk`; 1 = pressed.
- `press`, output, 1: one-cycle strobe on an accepted press.
- `release`, output, 1: one-cycle strobe when the button goes up after an accepted press.
- `long_press`, output, 1: one-cycle strobe after the button has been held `HOLD_CYCLES` cycles.
- `repeat`, output, 1: one-cycle strobe every `REPEAT_CYCLES` cycles while in HELD.
- `held`, output, 1: level, high while in HELD.

## Operation
- All outputs are registered. The internal counter width is ceil(log2(max(HOLD_CYCLES, REPEAT_CYCLES))) bits. The counter never wraps: it is cleared before it reaches its terminal value.
- State machine states: ARM, IDLE, PRESSED, HELD.
- Reset (`rst`=1 at an edge): state ARM, counter 0, all five outputs 0. `rst` overrides every other input.
- ARM:
  - `btn`=0 → IDLE.
  - `btn`=1 → stay in ARM.
  - Result: a button held through reset produces no events until it has been seen up.
- IDLE:
  - `btn`=1 → PRESSED, `press`<=1, counter<=0.
  - `btn`=0 → stay in IDLE.
- PRESSED, in priority order:
  - `btn`=0 → IDLE, `release`<=1.
  - Else counter == HOLD_CYCLES-1 → HELD, `long_press`<=1, counter<=0.
  - Else counter += 1.
- HELD, in priority order:
  - `btn`=0 → IDLE, `release`<=1.
  - Else counter == REPEAT_CYCLES-1 → `repeat`<=1, counter<=0.
  - Else counter += 1.
- Strobes default to 0 every cycle unless set above. At most one of `press`, `release`, `long_press`, `repeat` is high in any cycle.
- `held` is a registered copy of (next state == HELD). It rises with `long_press` and falls with `release`.

## Timing
- Latency: if `btn` is first sampled 1 in IDLE at edge k, `press` is high for exactly the cycle following edge k.
- `long_press` is high after edge k+HOLD_CYCLES, provided `btn` was sampled 1 at edges k+1 … k+HOLD_CYCLES.
- `repeat` is high after edges k+HOLD_CYCLES+n·REPEAT_CYCLES, for n = 1, 2, …, while `btn` stays 1.
- `release` is high in the cycle after the first edge at which `btn` is sampled 0 in PRESSED or HELD.
- A release at the same edge where the counter hits its terminal value yields `release` only. No `long_press` or `repeat` is emitted.
- Fastest re-press: from `release` to the next `press` takes 2 edges (`btn` must go 0 → 1). IDLE needs one edge with `btn`=1.
- A 1-cycle-wide `btn` pulse in IDLE yields `press` followed by `release` in the next cycle.
- `rst` asserted mid-PRESSED or mid-HELD: all outputs are 0 in the next cycle, and no `release` is emitted.

## Test plan
Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4.
- Short press: `rst` 2 cycles, `btn`=1 at edge 10 for 3 edges, then 0 → `press` after edge 10, `release` after edge 13, no `long_press`, `held`=0 throughout.
- Long hold with repeats: `btn`=1 at edge 10 held 20 edges, then 0 → `press`@10, `long_press`@18, `held`=1 from 18, `repeat`@22 and @26, `release`@30, `held`=0 from 30.
- Release at terminal count: `btn`=1 at edge 10 and sampled 0 at edge 18 → `release`@18, no `long_press`, `held` stays 0.
- Button held through reset: `btn`=1 during and 10 cycles after `rst` → no strobes. `btn`=0 one edge, then 1 → `press` one cycle later.
- Reset mid-HELD: reach HELD, then `rst`=1 at edge 22 → all outputs 0 after edge 22, no `repeat` or `release`, state ARM while `btn`=1.
- Rapid toggling: `btn` alternates 1/0 each edge for 10 edges starting in IDLE → `press` and `release` strobes alternate, 5 of each, never two strobes in one cycle.

Source files
------------

// File: rtl/press_decoder.sv
// Turns a debounced, clk-synchronous button level into one-cycle key strobes:
// press, release, long-press and auto-repeat, plus a held level.
module press_decoder #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic key_release,
    output logic long_press,
    output logic key_repeat,
    output logic held
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {ARM, IDLE, PRESSED, HELD} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            press_next, release_next, long_next, repeat_next, held_next;

    // State, counter and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ARM;
            cnt_reg     <= '0;
            press       <= 1'b0;
            key_release <= 1'b0;
            long_press  <= 1'b0;
            key_repeat  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            press       <= press_next;
            key_release <= release_next;
            long_press  <= long_next;
            key_repeat  <= repeat_next;
            held        <= held_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ARM: begin
                if (!btn) state_next = IDLE;
            end
            IDLE: begin
                if (btn) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end
            end
            PRESSED: begin
                if (!btn) begin
                    state_next = IDLE;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!btn) begin
                    state_next = IDLE;
                end else if (cnt_reg == REPEAT_LAST) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ARM;
        endcase
    end

    // A release on the terminal-count edge wins over long_press/repeat.
    always_comb begin
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        unique case (state_reg)
            IDLE:    press_next = btn;
            PRESSED: begin
                release_next = !btn;
                long_next    = btn && (cnt_reg == HOLD_LAST);
            end
            HELD: begin
                release_next = !btn;
                repeat_next  = btn && (cnt_reg == REPEAT_LAST);
            end
            default: ;
        endcase
        held_next = (state_next == HELD);
    end

endmodule

// File: tb/tb_press_decoder.sv
// Randomized and directed stimulus against a timing-based reference model;
// expected output vectors are queued per cycle and checked by a separate monitor.
module tb_press_decoder;

    localparam int HOLD   = 8;
    localparam int REPEAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic press, key_release, long_press, key_repeat, held;

    int checks = 0;
    int errors = 0;

    // Expected {press, release, long_press, repeat, held} after each edge.
    logic [4:0] exp_q[$];

    // Reference model: whether the button has been seen up since reset,
    // whether a press is in progress, and how many edges since the press edge.
    bit armed  = 1'b0;
    bit active = 1'b0;
    int t      = 0;

    int press_seen   = 0;
    int release_seen = 0;

    press_decoder #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .press      (press),
        .key_release(key_release),
        .long_press (long_press),
        .key_repeat (key_repeat),
        .held       (held)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic b, input logic r);
        logic [4:0] e;
        e = 5'b0;
        if (r) begin
            armed  = 1'b0;
            active = 1'b0;
        end else if (!armed) begin
            if (!b) armed = 1'b1;
        end else if (!active) begin
            if (b) begin
                active = 1'b1;
                t      = 0;
                e[4]   = 1'b1;
            end
        end else if (!b) begin
            active = 1'b0;
            e[3]   = 1'b1;
        end else begin
            t = t + 1;
            if (t == HOLD) e[2] = 1'b1;
            if (t > HOLD && ((t - HOLD) % REPEAT) == 0) e[1] = 1'b1;
            if (t >= HOLD) e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        btn = b;
        rst = r;
        @(posedge clk);
        exp_q.push_back(model(b, r));
    endtask

    task automatic steps(input logic b, input logic r, input int n);
        for (int i = 0; i < n; i++) step(b, r);
    endtask

    // Monitor: every cycle an expectation is pending, compare the DUT outputs.
    initial begin
        logic [4:0] act;
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {press, key_release, long_press, key_repeat, held};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got p/r/l/rp/h=%b required %b", $time, act, e);
                end
                checks++;
                if ($countones({press, key_release, long_press, key_repeat}) > 1) begin
                    errors++;
                    $display("FAIL one_strobe @%0t: got %b required at most one strobe", $time, act[4:1]);
                end
                if (press)       press_seen++;
                if (key_release) release_seen++;
                if (act[4:1] != 4'b0)
                    $display("@%0t strobe p/r/l/rp=%b held=%b", $time, act[4:1], act[0]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, r0;
        int run;
        logic b;

        // Short press.
        steps(1'b0, 1'b1, 2);
        steps(1'b0, 1'b0, 8);
        steps(1'b1, 1'b0, 3);
        steps(1'b0, 1'b0, 5);

        // Long hold with repeats.
        steps(1'b1, 1'b0, 20);
        steps(1'b0, 1'b0, 5);

        // Release exactly at the terminal count.
        steps(1'b1, 1'b0, HOLD);
        steps(1'b0, 1'b0, 5);

        // Button held through reset, then seen up, then pressed.
        steps(1'b1, 1'b1, 2);
        steps(1'b1, 1'b0, 10);
        steps(1'b0, 1'b0, 1);
        steps(1'b1, 1'b0, 3);
        steps(1'b0, 1'b0, 3);

        // Reset mid-HELD, button still down afterwards.
        steps(1'b1, 1'b0, HOLD + 3);
        steps(1'b1, 1'b1, 1);
        steps(1'b1, 1'b0, 10);
        steps(1'b0, 1'b0, 3);

        // Rapid toggling: 5 presses and 5 releases.
        @(negedge clk);
        @(negedge clk);
        p0 = press_seen;
        r0 = release_seen;
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 1'b0);
        steps(1'b0, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (press_seen - p0 != 5 || release_seen - r0 != 5) begin
            errors++;
            $display("FAIL toggle_count: got press=%0d release=%0d required 5 and 5",
                     press_seen - p0, release_seen - r0);
        end

        // Random runs of btn levels with occasional resets.
        for (int k = 0; k < 300; k++) begin
            b   = $urandom_range(0, 1);
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(1, 25);
            for (int i = 0; i < run; i++)
                step(b, ($urandom_range(0, 150) == 0));
        end
        steps(1'b0, 1'b0, 3);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
